instr_fetch_unit: RTL and testbench

Fetch stage of the multi-cycle RISC-V CPU, directly upstream of the instruction memory.
- Owns the PC and drives the instruction-memory byte address.
- Captures the returned word into the instruction register (IR) together with the PC it came from.
- Advances the PC by 4 after each fetch; the control FSM can load a branch/jump target instead.
- Supports instruction memories with 0..N cycles of read latency.

---
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage of the multi-cycle RISC-V CPU. Owns the PC, drives the
//   instruction-memory byte address and captures the returned word into the
//   instruction register together with the PC it was fetched from.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   fetch_req    in   request one instruction fetch (sampled only in IDLE)
//   pc_we        in   load pc_next into PC (honoured only in IDLE)
//   pc_next      in   branch/jump target byte address
//   imem_a       out  instruction memory byte address (always equals pc)
//   imem_rd      in   instruction memory read data
//   instr        out  instruction register
//   instr_pc     out  PC of the word held in instr
//   pc           out  current PC register
//   pc_plus4     out  pc + 4, wraps modulo 2^32
//   instr_valid  out  one-cycle pulse after instr/instr_pc were updated
//   busy         out  high while a fetch is in progress
//   misaligned   out  sticky flag: fetch requested from a misaligned PC
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_LATENCY = 0,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic        pc_we,
   input  logic [31:0] pc_next,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        busy,
   output logic        misaligned
);

   localparam int unsigned CW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FETCH = 1'b1;

   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_pc;
   logic [31:0]   r_instr;
   logic [31:0]   r_instr_pc;
   logic          r_valid;
   logic          r_mis;

   logic [31:0]   w_pc_plus4;
   logic [31:0]   w_start_pc;

   assign w_pc_plus4 = r_pc + 32'd4;
   // A fetch requested together with pc_we is issued from the new PC, so the
   // alignment check has to look at pc_next in that case.
   assign w_start_pc = pc_we ? pc_next : r_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_pc       <= RESET_PC;
         r_instr    <= NOP_INSTR;
         r_instr_pc <= RESET_PC;
         r_valid    <= 1'b0;
         r_mis      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_state == S_IDLE) begin
            if (pc_we) begin
               r_pc  <= pc_next;
               r_mis <= 1'b0;
            end
            if (fetch_req) begin
               if (w_start_pc[1:0] == 2'b00) begin
                  r_state <= S_FETCH;
                  r_cnt   <= CNT_LOAD;
               end else begin
                  // Overrides the clear above when pc_we targets a misaligned PC.
                  r_mis <= 1'b1;
               end
            end
         end else begin
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - CW'(1);
            end else begin
               r_instr    <= imem_rd;
               r_instr_pc <= r_pc;
               r_pc       <= w_pc_plus4;
               r_valid    <= 1'b1;
               r_state    <= S_IDLE;
            end
         end
      end
   end

   assign imem_a      = r_pc;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_valid;
   assign busy        = (r_state == S_FETCH);
   assign misaligned  = r_mis;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Three fetch units (read latency 0, 2 and 3) share the control inputs and
//   each sees its own memory. A transaction-level reference model tracks every
//   unit; a vector table and hand sequences cover the documented corner cases.
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        fetch_req;
   logic        pc_we;
   logic [31:0] pc_next;

   logic [31:0] o_a     [3];
   logic [31:0] o_rd    [3];
   logic [31:0] o_instr [3];
   logic [31:0] o_ipc   [3];
   logic [31:0] o_pc    [3];
   logic [31:0] o_p4    [3];
   logic        o_v     [3];
   logic        o_b     [3];
   logic        o_m     [3];

   int tests;
   int fails;

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem = 32'h0010_0093;
         32'h0000_0004: mem = 32'h0010_0113;
         32'h0000_0008: mem = 32'h0020_8863;
         default:       mem = {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC35A} ^ 32'h0123_4567;
      endcase
   endfunction

   function automatic int lat(input int k);
      case (k)
         0:       lat = 0;
         1:       lat = 2;
         default: lat = 3;
      endcase
   endfunction

   always_comb begin
      for (int k = 0; k < 3; k++) o_rd[k] = mem(o_a[k]);
   end

   instr_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(0), .NOP_INSTR(NOP)) u_l0 (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_we(pc_we), .pc_next(pc_next),
      .imem_a(o_a[0]), .imem_rd(o_rd[0]), .instr(o_instr[0]), .instr_pc(o_ipc[0]),
      .pc(o_pc[0]), .pc_plus4(o_p4[0]), .instr_valid(o_v[0]), .busy(o_b[0]), .misaligned(o_m[0]));

   instr_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(2), .NOP_INSTR(NOP)) u_l2 (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_we(pc_we), .pc_next(pc_next),
      .imem_a(o_a[1]), .imem_rd(o_rd[1]), .instr(o_instr[1]), .instr_pc(o_ipc[1]),
      .pc(o_pc[1]), .pc_plus4(o_p4[1]), .instr_valid(o_v[1]), .busy(o_b[1]), .misaligned(o_m[1]));

   instr_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(3), .NOP_INSTR(NOP)) u_l3 (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_we(pc_we), .pc_next(pc_next),
      .imem_a(o_a[2]), .imem_rd(o_rd[2]), .instr(o_instr[2]), .instr_pc(o_ipc[2]),
      .pc(o_pc[2]), .pc_plus4(o_p4[2]), .instr_valid(o_v[2]), .busy(o_b[2]), .misaligned(o_m[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a fetch is "edges left until completion"
   logic [31:0] m_pc    [3];
   logic [31:0] m_instr [3];
   logic [31:0] m_ipc   [3];
   logic        m_v     [3];
   logic        m_m     [3];
   int          m_left  [3];

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_pc[k] = 32'h0; m_instr[k] = NOP; m_ipc[k] = 32'h0;
         m_v[k] = 1'b0; m_m[k] = 1'b0; m_left[k] = 0;
      end
   endtask

   task automatic model_edge();
      logic [31:0] tgt;
      if (reset) begin
         model_reset();
      end else begin
         for (int k = 0; k < 3; k++) begin
            m_v[k] = 1'b0;
            if (m_left[k] > 0) begin
               m_left[k] = m_left[k] - 1;
               if (m_left[k] == 0) begin
                  m_instr[k] = mem(m_pc[k]);
                  m_ipc[k]   = m_pc[k];
                  m_pc[k]    = m_pc[k] + 32'd4;
                  m_v[k]     = 1'b1;
               end
            end else begin
               tgt = pc_we ? pc_next : m_pc[k];
               if (pc_we) begin
                  m_pc[k] = pc_next;
                  m_m[k]  = 1'b0;
               end
               if (fetch_req) begin
                  if (tgt[1:0] != 2'b00) m_m[k] = 1'b1;
                  else m_left[k] = lat(k) + 1;
               end
            end
         end
      end
   endtask

   task automatic check_model();
      logic [31:0] e4;
      for (int k = 0; k < 3; k++) begin
         e4 = m_pc[k] + 32'd4;
         tests++;
         if (o_pc[k] !== m_pc[k] || o_a[k] !== m_pc[k] || o_p4[k] !== e4 ||
             o_instr[k] !== m_instr[k] || o_ipc[k] !== m_ipc[k] || o_v[k] !== m_v[k] ||
             o_b[k] !== (m_left[k] > 0) || o_m[k] !== m_m[k]) begin
            fails++;
            $display("FAIL model_L%0d t=%0t got pc=%h a=%h p4=%h ir=%h ipc=%h v=%b b=%b m=%b exp pc=%h p4=%h ir=%h ipc=%h v=%b b=%b m=%b",
                     lat(k), $time, o_pc[k], o_a[k], o_p4[k], o_instr[k], o_ipc[k], o_v[k], o_b[k], o_m[k],
                     m_pc[k], e4, m_instr[k], m_ipc[k], m_v[k], (m_left[k] > 0), m_m[k]);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        rst, fr, we;
      logic [31:0] nx;
      logic [31:0] e_pc, e_instr, e_ipc;
      logic        e_v, e_b, e_m;
   } vec_t;

   vec_t tbl [21];

   initial begin
      int busy_cnt;
      logic got_v;
      logic addr_ok;
      logic [31:0] tmp;
      int r;

      tests = 0; fails = 0;
      reset = 1'b1; fetch_req = 1'b0; pc_we = 1'b0; pc_next = 32'h0;
      model_reset();

      //          rst   fr    we    nx             pc             instr                ipc            v     b     m
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         NOP,                 32'h0,         1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         NOP,                 32'h0,         1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h0010_0093,       32'h0,         1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h4,         32'h0010_0093,       32'h0,         1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'h0010_0113,       32'h4,         1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h8,         32'h0010_0113,       32'h4,         1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         32'h0020_8863,       32'h8,         1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         32'h0020_8863,       32'h8,         1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h18,        32'h18,        32'h0020_8863,       32'h8,         1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h1C,        mem(32'h18),         32'h18,        1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h6,         32'h6,         mem(32'h18),         32'h18,        1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h6,         mem(32'h18),         32'h18,        1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h6,         mem(32'h18),         32'h18,        1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h8,         32'h8,         mem(32'h18),         32'h18,        1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h8,         mem(32'h18),         32'h18,        1'b0, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         32'h0020_8863,       32'h8,         1'b1, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0020_8863,       32'h8,         1'b0, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         mem(32'hFFFF_FFFC),  32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 1'b1, 32'h21,        32'h21,        mem(32'hFFFF_FFFC),  32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1};
      tbl[19] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h21,        mem(32'hFFFF_FFFC),  32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1};
      tbl[20] = '{1'b0, 1'b0, 1'b1, 32'h20,        32'h20,        mem(32'hFFFF_FFFC),  32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 21; i++) begin
         reset = tbl[i].rst; fetch_req = tbl[i].fr; pc_we = tbl[i].we; pc_next = tbl[i].nx;
         step();
         tests++;
         if (o_pc[0] !== tbl[i].e_pc || o_p4[0] !== tbl[i].e_pc + 32'd4 || o_a[0] !== tbl[i].e_pc ||
             o_instr[0] !== tbl[i].e_instr || o_ipc[0] !== tbl[i].e_ipc ||
             o_v[0] !== tbl[i].e_v || o_b[0] !== tbl[i].e_b || o_m[0] !== tbl[i].e_m) begin
            fails++;
            $display("FAIL table[%0d] got pc=%h ir=%h ipc=%h v=%b b=%b m=%b exp pc=%h ir=%h ipc=%h v=%b b=%b m=%b",
                     i, o_pc[0], o_instr[0], o_ipc[0], o_v[0], o_b[0], o_m[0],
                     tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_v, tbl[i].e_b, tbl[i].e_m);
         end
      end

      // Latency-2 unit: busy for three cycles, requests during busy ignored
      reset = 1'b1; fetch_req = 1'b0; pc_we = 1'b0; pc_next = 32'h0;
      step();
      reset = 1'b0; fetch_req = 1'b1;
      step();
      pc_we = 1'b1; pc_next = 32'h40;
      busy_cnt = 0; got_v = 1'b0; addr_ok = 1'b1;
      for (int i = 0; i < 10 && !got_v; i++) begin
         if (o_b[1]) begin
            busy_cnt++;
            if (o_a[1] !== 32'h0) addr_ok = 1'b0;
         end
         step();
         if (o_v[1]) got_v = 1'b1;
      end
      fetch_req = 1'b0; pc_we = 1'b0;
      chk("lat2_completed", {31'b0, got_v}, 32'd1);
      chk("lat2_busy_cycles", busy_cnt, 32'd3);
      chk("lat2_addr_stable", {31'b0, addr_ok}, 32'd1);
      chk("lat2_instr", o_instr[1], 32'h0010_0093);
      chk("lat2_instr_pc", o_ipc[1], 32'h0);
      chk("lat2_pc", o_pc[1], 32'h4);
      step();

      // Latency-3 unit: reset one cycle into a fetch aborts it immediately
      reset = 1'b1;
      step();
      reset = 1'b0; fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      step();
      chk("lat3_busy_before_reset", {31'b0, o_b[2]}, 32'd1);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      chk("async_rst_instr", o_instr[2], NOP);
      chk("async_rst_pc", o_pc[2], 32'h0);
      chk("async_rst_busy", {31'b0, o_b[2]}, 32'd0);
      chk("async_rst_valid", {31'b0, o_v[2]}, 32'd0);
      check_model();
      step();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) step();

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         fetch_req = 1'($urandom_range(0, 1));
         pc_we     = ($urandom_range(0, 3) == 0);
         r = int'($urandom_range(0, 9));
         tmp = $urandom;
         if (r == 0) pc_next = 32'hFFFF_FFFC;
         else if (r == 1) pc_next = tmp;
         else if (r == 2) pc_next = 32'($urandom_range(0, 3)) << 2;
         else pc_next = tmp & 32'hFFFF_FFFC;
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0; fetch_req = 1'b0; pc_we = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
